// File: rtl/rmt_axis_pkt_sink.sv
// AXI-Stream debug sink for the RMT pipeline output: optional periodic backpressure,
// saturating packet/byte statistics, first-beat capture and sticky tkeep/length error flags.
module rmt_axis_pkt_sink #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int MAX_PKT_BYTES        = 9600,
    parameter int BP_PERIOD            = 4
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic                              bp_en,
    input  logic                              clr_stats,
    output logic                              pkt_done,
    output logic [31:0]                       pkt_cnt,
    output logic [31:0]                       byte_cnt,
    output logic [15:0]                       last_pkt_len,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    last_hdr,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   last_tuser,
    output logic [2:0]                        err_flags
);
    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int POP_W  = $clog2(KEEP_W + 1);
    localparam int BPC_W  = $clog2(BP_PERIOD);
    localparam logic [BPC_W-1:0] BP_LAST = BPC_W'(BP_PERIOD - 1);
    localparam logic [16:0]      MAX_LEN = 17'(MAX_PKT_BYTES);

    function automatic logic [POP_W-1:0] popcount(input logic [KEEP_W-1:0] k);
        logic [POP_W-1:0] s;
        s = '0;
        for (int i = 0; i < KEEP_W; i++) s = s + POP_W'(k[i]);
        return s;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t            state_q, state_d;
    logic [BPC_W-1:0]  bp_cnt, bp_cnt_nxt;
    logic              tready_q;
    logic              fire;
    logic [POP_W-1:0]  beat_bytes;
    logic [15:0]       run_len_q, len_beat;
    logic              keep_zero, keep_noncontig, oversize;
    logic              err_oversize, err_noncontig, err_zero;

    assign s_axis_tready = tready_q;
    assign fire          = s_axis_tvalid & tready_q;
    assign err_flags     = {err_oversize, err_noncontig, err_zero};

    // tready is registered so it never depends on tvalid; the counter free-runs while bp_en=1
    assign bp_cnt_nxt = (bp_cnt == BP_LAST) ? '0 : bp_cnt + BPC_W'(1);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            bp_cnt   <= '0;
            tready_q <= 1'b1;
        end else if (!bp_en) begin
            bp_cnt   <= '0;
            tready_q <= 1'b1;
        end else begin
            bp_cnt   <= bp_cnt_nxt;
            tready_q <= (bp_cnt_nxt != BP_LAST);
        end
    end

    always_comb begin
        state_d        = state_q;
        beat_bytes     = popcount(s_axis_tkeep);
        len_beat       = (state_q == IDLE) ? 16'(beat_bytes)
                                           : sat_add16(run_len_q, 16'(beat_bytes));
        keep_zero      = (s_axis_tkeep == '0);
        keep_noncontig = ((s_axis_tkeep & (s_axis_tkeep + KEEP_W'(1))) != '0) ||
                         (!s_axis_tlast && (s_axis_tkeep != '1));
        oversize       = ({1'b0, len_beat} > MAX_LEN);
        if (fire) state_d = s_axis_tlast ? IDLE : IN_PKT;
    end

    // Accept stage: statistics and captures land one cycle after the accepting edge
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            run_len_q     <= '0;
            pkt_done      <= 1'b0;
            pkt_cnt       <= '0;
            byte_cnt      <= '0;
            last_pkt_len  <= '0;
            last_hdr      <= '0;
            last_tuser    <= '0;
            err_oversize  <= 1'b0;
            err_noncontig <= 1'b0;
            err_zero      <= 1'b0;
        end else begin
            state_q  <= state_d;
            pkt_done <= fire & s_axis_tlast;
            if (fire) run_len_q <= len_beat;

            // A completing packet still reports its length even when stats are being cleared
            if (fire && s_axis_tlast) last_pkt_len <= len_beat;
            else if (clr_stats)       last_pkt_len <= '0;

            if (clr_stats) begin
                pkt_cnt       <= '0;
                byte_cnt      <= '0;
                last_hdr      <= '0;
                last_tuser    <= '0;
                err_oversize  <= 1'b0;
                err_noncontig <= 1'b0;
                err_zero      <= 1'b0;
            end else if (fire) begin
                byte_cnt <= sat_add32(byte_cnt, 32'(beat_bytes));
                if (s_axis_tlast) pkt_cnt <= sat_add32(pkt_cnt, 32'd1);
                if (state_q == IDLE) begin
                    last_hdr   <= s_axis_tdata;
                    last_tuser <= s_axis_tuser;
                end
                if (keep_zero)      err_zero      <= 1'b1;
                if (keep_noncontig) err_noncontig <= 1'b1;
                if (oversize)       err_oversize  <= 1'b1;
            end
        end
    end
endmodule
